// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch and load/store request/response bundle between pipeline and arbiter.
// Revision: 1.0
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_ack;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_gnt, i_ack, i_rdata, d_gnt, d_ack, d_rdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output i_gnt, i_ack, i_rdata, d_gnt, d_ack, d_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one registered-read memory between fetch and load/store ports.
// Optional fetch anti-starvation with macro ARB_FAIR_EN. Revision: 1.0
`default_nettype none

module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mem_port_arbiter_if.slave  bus,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  wire logic [DW-1:0] mem_rdata,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state;
  logic          owner_d;
  logic          idle;
  logic          grant_d;
  logic          grant_i;
  logic          force_fetch;
  logic          i_ack_r;
  logic          d_ack_r;
  logic [DW-1:0] i_rdata_r;
  logic [DW-1:0] d_rdata_r;

`ifdef ARB_FAIR_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] cnt;

  assign force_fetch = bus.i_req && (cnt == CW'(STARVE_MAX));

  // Counts data grants that passed over a waiting fetch; saturates at STARVE_MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (grant_i) begin
      cnt <= '0;
    end else if (grant_d && bus.i_req && (cnt != CW'(STARVE_MAX))) begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  // Grants are combinational and held low while reset is asserted.
  assign idle    = (state == IDLE) && !rst;
  assign grant_d = idle && bus.d_req && !force_fetch;
  assign grant_i = idle && bus.i_req && !grant_d;

  assign bus.d_gnt   = grant_d;
  assign bus.i_gnt   = grant_i;
  assign bus.i_ack   = i_ack_r;
  assign bus.d_ack   = d_ack_r;
  assign bus.i_rdata = i_rdata_r;
  assign bus.d_rdata = d_rdata_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      i_ack_r   <= 1'b0;
      d_ack_r   <= 1'b0;
      i_rdata_r <= '0;
      d_rdata_r <= '0;
    end else begin
      i_ack_r <= 1'b0;
      d_ack_r <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner_d   <= 1'b1;
            mem_addr  <= bus.d_addr;
            mem_wdata <= bus.d_wdata;
            mem_we    <= bus.d_we;
            busy      <= 1'b1;
            state     <= ISSUE;
          end else if (grant_i) begin
            owner_d  <= 1'b0;
            mem_addr <= bus.i_addr;
            mem_we   <= 1'b0;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          // Memory samples address/write on this closing edge.
          mem_we <= 1'b0;
          state  <= RESP;
        end
        RESP: begin
          if (owner_d) begin
            d_ack_r   <= 1'b1;
            d_rdata_r <= mem_rdata;
          end else begin
            i_ack_r   <= 1'b1;
            i_rdata_r <= mem_rdata;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_we <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter against a behavioural memory.
// Revision: 1.0
`default_nettype none

module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_mem = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:63];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 64; k++) mem[k] <= '0;
      mem[8]    <= 32'hDEADBEEF;
      mem_rdata <= '0;
    end else begin
      if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[5:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One full transaction on one port; request held until its ack.
  task automatic xact(input bit is_d, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input string tag);
    @(negedge clk);
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = addr;
    end
    #1;
    check({tag, " gnt"}, is_d ? bus.d_gnt : bus.i_gnt, 1);
    @(posedge clk); #1;
    check({tag, " issue busy"}, busy, 1);
    check({tag, " issue mem_we"}, mem_we, is_d & we);
    check({tag, " issue mem_addr"}, mem_addr, addr);
    @(posedge clk); #1;
    check({tag, " resp mem_we"}, mem_we, 0);
    check({tag, " resp ack early"}, is_d ? bus.d_ack : bus.i_ack, 0);
    @(posedge clk); #1;
    check({tag, " ack"}, is_d ? bus.d_ack : bus.i_ack, 1);
    check({tag, " other ack"}, is_d ? bus.i_ack : bus.d_ack, 0);
    if (!(is_d && we)) check({tag, " rdata"}, is_d ? bus.d_rdata : bus.i_rdata, exp_rd);
    check({tag, " busy done"}, busy, 0);
    if (is_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
  endtask

  initial begin
    int nd, nf;
    logic [19:0] pattern;

    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    // Power-on reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; init_mem = 1'b0;
    #1;
    check("rst busy", busy, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst i_ack", bus.i_ack, 0);
    check("rst d_ack", bus.d_ack, 0);
    check("rst i_rdata", bus.i_rdata, 0);
    check("rst d_gnt", bus.d_gnt, 0);

    // Fetch-only read, store then load
    xact(1'b0, 1'b0, 32'd8, 32'd0, 32'hDEADBEEF, "fetch8");
    xact(1'b1, 1'b1, 32'd4, 32'h12345678, 32'd0, "store4");
    check("store4 mem_wdata", mem_wdata, 32'h12345678);
    xact(1'b1, 1'b0, 32'd4, 32'd0, 32'h12345678, "load4");
    check("fetch rdata held", bus.i_rdata, 32'hDEADBEEF);

    // Contention: data wins, fetch follows in the next idle
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'd8;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'd4;
    #1;
    check("cont d_gnt", bus.d_gnt, 1);
    check("cont i_gnt", bus.i_gnt, 0);
    repeat (3) @(posedge clk);
    #1;
    check("cont d_ack", bus.d_ack, 1);
    check("cont d_rdata", bus.d_rdata, 32'h12345678);
    check("cont i_ack early", bus.i_ack, 0);
    bus.d_req = 1'b0;
    #1;
    check("cont i_gnt later", bus.i_gnt, 1);
    repeat (3) @(posedge clk);
    #1;
    check("cont i_ack", bus.i_ack, 1);
    check("cont i_rdata", bus.i_rdata, 32'hDEADBEEF);
    check("cont d_ack late", bus.d_ack, 0);
    bus.i_req = 1'b0;

    // Reset mid-ISSUE of a store to 12
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'd12; bus.d_wdata = 32'hAAAA5555;
    #1;
    check("abort gnt", bus.d_gnt, 1);
    @(posedge clk); #1;
    check("abort issue mem_we", mem_we, 1);
    #2 rst = 1'b1;
    #1;
    check("abort mem_we", mem_we, 0);
    check("abort busy", busy, 0);
    check("abort mem_addr", mem_addr, 0);
    check("abort mem_wdata", mem_wdata, 0);
    check("abort d_gnt", bus.d_gnt, 0);
    check("abort i_rdata", bus.i_rdata, 0);
    bus.d_req = 1'b0;
    @(posedge clk); #1;
    check("abort no d_ack", bus.d_ack, 0);
    rst = 1'b0;
    xact(1'b1, 1'b0, 32'd12, 32'd0, 32'd0, "load12");

    // Continuous contention over 20 transactions
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nd = 0; nf = 0; pattern = '0;
    bus.i_req = 1'b1; bus.i_addr = 32'd8;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'd4;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (bus.d_gnt) nd++;
      if (bus.i_gnt) begin
        pattern[nd + nf] = 1'b1;
        nf++;
      end
      @(negedge clk);
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    check("starve total grants", 64'(nd + nf), 20);
`ifdef ARB_FAIR_EN
    check("fair data grants", 64'(nd), 16);
    check("fair fetch grants", 64'(nf), 4);
    check("fair pattern", 64'(pattern[5:0]), 64'h10);
`else
    check("strict data grants", 64'(nd), 20);
    check("strict fetch grants", 64'(nf), 0);
    check("strict pattern", 64'(pattern), 0);
`endif
    repeat (4) @(posedge clk);
    #1;
    check("end busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

`default_nettype wire
